// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel divider, h/v counters, sync,
// blanking, data-enable, line/game ticks and a frame counter, all registered and aligned.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE  = 800,
   parameter int unsigned H_FP      = 40,
   parameter int unsigned H_SYNC    = 128,
   parameter int unsigned H_BP      = 88,
   parameter int unsigned V_ACTIVE  = 600,
   parameter int unsigned V_FP      = 1,
   parameter int unsigned V_SYNC    = 4,
   parameter int unsigned V_BP      = 23,
   parameter bit          H_POL     = 1'b1,
   parameter bit          V_POL     = 1'b1,
   parameter int unsigned PIX_DIV   = 1,
   parameter int unsigned TICK_LINE = V_ACTIVE,
   parameter int unsigned CNT_W     = 11,
   parameter int unsigned FRAME_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic [CNT_W-1:0]   hcount,
   output logic [CNT_W-1:0]   vcount,
   output logic               hsync,
   output logic               vsync,
   output logic               hblnk,
   output logic               vblnk,
   output logic               de,
   output logic               line_tick,
   output logic               timing_tick,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;
   localparam int unsigned DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   // Reject configurations the counters cannot represent.
   if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
       CNT_W == 0 || FRAME_W == 0) begin : g_zero_param
      $error("vga_timing_gen: zero-valued timing parameter");
   end
   if (PIX_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: PIX_DIV must be at least 1");
   end
   if (TICK_LINE >= V_TOTAL) begin : g_bad_tick
      $error("vga_timing_gen: TICK_LINE must be below V_TOTAL");
   end
   if (((H_TOTAL - 1) >> CNT_W) != 0 || ((V_TOTAL - 1) >> CNT_W) != 0) begin : g_cnt_ovf
      $error("vga_timing_gen: CNT_W too narrow for raster totals");
   end

   logic [DIV_W-1:0]   div_q;
   logic [DIV_W-1:0]   div_nxt;
   logic               advance_c;
   logic               h_wrap_c;
   logic               v_wrap_c;
   logic [CNT_W-1:0]   h_nxt;
   logic [CNT_W-1:0]   v_nxt;
   logic [FRAME_W-1:0] frame_nxt;
   logic               hblnk_nxt;
   logic               vblnk_nxt;
   logic               hsync_nxt;
   logic               vsync_nxt;
   logic               line_tick_nxt;
   logic               timing_tick_nxt;

   // Next raster position.
   always_comb begin
      div_nxt   = div_q;
      h_nxt     = hcount;
      v_nxt     = vcount;
      frame_nxt = frame_cnt;
      advance_c = en && (div_q == DIV_W'(PIX_DIV - 1));
      h_wrap_c  = (hcount == CNT_W'(H_TOTAL - 1));
      v_wrap_c  = (vcount == CNT_W'(V_TOTAL - 1));
      if (en) begin
         div_nxt = advance_c ? '0 : div_q + DIV_W'(1);
      end
      if (advance_c) begin
         if (h_wrap_c) begin
            h_nxt = '0;
            if (v_wrap_c) begin
               v_nxt     = '0;
               frame_nxt = frame_cnt + FRAME_W'(1);
            end else begin
               v_nxt = vcount + CNT_W'(1);
            end
         end else begin
            h_nxt = hcount + CNT_W'(1);
         end
      end
   end

   // Decode from the next position so registered flags line up with the counts.
   always_comb begin
      hblnk_nxt       = (h_nxt >= CNT_W'(H_ACTIVE));
      vblnk_nxt       = (v_nxt >= CNT_W'(V_ACTIVE));
      hsync_nxt       = ((h_nxt >= CNT_W'(HS_START)) && (h_nxt < CNT_W'(HS_END))) ? H_POL : !H_POL;
      vsync_nxt       = ((v_nxt >= CNT_W'(VS_START)) && (v_nxt < CNT_W'(VS_END))) ? V_POL : !V_POL;
      line_tick_nxt   = advance_c && h_wrap_c;
      timing_tick_nxt = advance_c && h_wrap_c && (v_nxt == CNT_W'(TICK_LINE));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q       <= '0;
         hcount      <= '0;
         vcount      <= '0;
         frame_cnt   <= '0;
         hblnk       <= 1'b0;
         vblnk       <= 1'b0;
         de          <= 1'b1;
         hsync       <= !H_POL;
         vsync       <= !V_POL;
         line_tick   <= 1'b0;
         timing_tick <= 1'b0;
      end else begin
         div_q       <= div_nxt;
         hcount      <= h_nxt;
         vcount      <= v_nxt;
         frame_cnt   <= frame_nxt;
         hblnk       <= hblnk_nxt;
         vblnk       <= vblnk_nxt;
         de          <= !hblnk_nxt && !vblnk_nxt;
         hsync       <= hsync_nxt;
         vsync       <= vsync_nxt;
         line_tick   <= line_tick_nxt;
         timing_tick <= timing_tick_nxt;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, PIX_DIV=2 with inverted
// polarity, and a tiny raster for full-frame behaviour, sharing clk/rst/en.
module tb_vga_timing_gen;

   logic clk;
   logic rst;
   logic en;

   logic [10:0] d_hcount, d_vcount, q_hcount, q_vcount, s_hcount, s_vcount;
   logic        d_hsync, d_vsync, d_hblnk, d_vblnk, d_de, d_lt, d_tt;
   logic        q_hsync, q_vsync, q_hblnk, q_vblnk, q_de, q_lt, q_tt;
   logic        s_hsync, s_vsync, s_hblnk, s_vblnk, s_de, s_lt, s_tt;
   logic [15:0] d_frame, q_frame, s_frame;

   int checks   = 0;
   int failures = 0;
   int d_lt_n   = 0;
   int q_lt_n   = 0;
   int s_lt_n   = 0;
   int s_tt_n   = 0;
   int d_tt_n   = 0;

   vga_timing_gen u_dut (
      .clk(clk), .rst(rst), .en(en),
      .hcount(d_hcount), .vcount(d_vcount), .hsync(d_hsync), .vsync(d_vsync),
      .hblnk(d_hblnk), .vblnk(d_vblnk), .de(d_de),
      .line_tick(d_lt), .timing_tick(d_tt), .frame_cnt(d_frame)
   );

   vga_timing_gen #(.PIX_DIV(2), .H_POL(1'b0), .V_POL(1'b0)) u_div2 (
      .clk(clk), .rst(rst), .en(en),
      .hcount(q_hcount), .vcount(q_vcount), .hsync(q_hsync), .vsync(q_vsync),
      .hblnk(q_hblnk), .vblnk(q_vblnk), .de(q_de),
      .line_tick(q_lt), .timing_tick(q_tt), .frame_cnt(q_frame)
   );

   // 15 x 10 raster: hsync 10..12, vsync lines 7..8, tick on line 6.
   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .TICK_LINE(6)
   ) u_small (
      .clk(clk), .rst(rst), .en(en),
      .hcount(s_hcount), .vcount(s_vcount), .hsync(s_hsync), .vsync(s_vsync),
      .hblnk(s_hblnk), .vblnk(s_vblnk), .de(s_de),
      .line_tick(s_lt), .timing_tick(s_tt), .frame_cnt(s_frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic count_ticks();
      if (d_lt) d_lt_n++;
      if (q_lt) q_lt_n++;
      if (s_lt) s_lt_n++;
      if (s_tt) s_tt_n++;
      if (d_tt) d_tt_n++;
   endtask

   initial begin
      int k;
      rst = 1'b0;
      en  = 1'b1;
      repeat (3) step();
      check("rst_hcount", 32'(d_hcount), 0);
      check("rst_vcount", 32'(d_vcount), 0);
      check("rst_hsync", 32'(d_hsync), 0);
      check("rst_vsync", 32'(d_vsync), 0);
      check("rst_hblnk", 32'(d_hblnk), 0);
      check("rst_vblnk", 32'(d_vblnk), 0);
      check("rst_de", 32'(d_de), 1);
      check("rst_ticks", 32'({d_lt, d_tt}), 0);
      check("rst_frame", 32'(d_frame), 0);
      check("rst_q_sync", 32'({q_hsync, q_vsync}), 3);

      rst = 1'b1;
      for (int n = 1; n <= 4300; n++) begin
         step();
         count_ticks();
         case (n)
            1:    begin check("first_h", 32'(d_hcount), 1); check("q_first_h", 32'(q_hcount), 0);
                        check("first_lt", 32'(d_lt), 0); end
            2:    check("q_second_h", 32'(q_hcount), 1);
            10:   check("s_hsync_on", 32'(s_hsync), 1);
            13:   check("s_hsync_off", 32'(s_hsync), 0);
            90:   begin check("s_tt_on", 32'(s_tt), 1); check("s_tt_v", 32'(s_vcount), 6);
                        check("s_tt_h", 32'(s_hcount), 0); check("s_vblnk", 32'(s_vblnk), 1); end
            91:   check("s_tt_off", 32'(s_tt), 0);
            104:  check("s_vsync_pre", 32'(s_vsync), 0);
            105:  check("s_vsync_on", 32'(s_vsync), 1);
            134:  check("s_vsync_last", 32'(s_vsync), 1);
            135:  check("s_vsync_off", 32'(s_vsync), 0);
            149:  check("s_frame_pre", 32'(s_frame), 0);
            150:  begin check("s_frame_wrap", 32'(s_frame), 1); check("s_wrap_v", 32'(s_vcount), 0);
                        check("s_wrap_h", 32'(s_hcount), 0); check("s_wrap_lt", 32'(s_lt), 1);
                        check("s_wrap_tt", 32'(s_tt), 0); end
            799:  check("hblnk_pre", 32'({d_hblnk, d_de}), 1);
            800:  begin check("hblnk_on", 32'({d_hblnk, d_de}), 2); check("h800", 32'(d_hcount), 800); end
            839:  check("hsync_pre", 32'(d_hsync), 0);
            840:  check("hsync_on", 32'(d_hsync), 1);
            967:  check("hsync_last", 32'(d_hsync), 1);
            968:  check("hsync_off", 32'(d_hsync), 0);
            1055: check("lt_pre", 32'(d_lt), 0);
            1056: begin check("lt_on", 32'(d_lt), 1); check("wrap_h", 32'(d_hcount), 0);
                        check("wrap_v", 32'(d_vcount), 1); check("wrap_de", 32'(d_de), 1); end
            1057: check("lt_off", 32'(d_lt), 0);
            1679: check("q_hsync_pre", 32'(q_hsync), 1);
            1680: begin check("q_hsync_on", 32'(q_hsync), 0); check("q_h840", 32'(q_hcount), 840); end
            1935: check("q_hsync_last", 32'(q_hsync), 0);
            1936: check("q_hsync_off", 32'(q_hsync), 1);
            2112: begin check("q_lt_on", 32'(q_lt), 1); check("q_lt_v", 32'(q_vcount), 1); end
            2113: check("q_lt_off", 32'(q_lt), 0);
            4300: begin check("s_end_frame", 32'(s_frame), 28); check("s_end_v", 32'(s_vcount), 6);
                        check("s_end_h", 32'(s_hcount), 10); check("d_end_v", 32'(d_vcount), 4);
                        check("d_end_h", 32'(d_hcount), 76); end
            default: ;
         endcase
      end
      check("d_lt_count", 32'(d_lt_n), 4);
      check("q_lt_count", 32'(q_lt_n), 2);
      check("s_lt_count", 32'(s_lt_n), 286);
      check("s_tt_count", 32'(s_tt_n), 29);
      check("d_tt_count", 32'(d_tt_n), 0);

      // Asynchronous reset mid-frame, observed before any clock edge.
      rst = 1'b0;
      #1;
      check("arst_h", 32'(d_hcount), 0);
      check("arst_v", 32'(d_vcount), 0);
      check("arst_s_frame", 32'(s_frame), 0);
      check("arst_s_v", 32'(s_vcount), 0);
      check("arst_q_h", 32'(q_hcount), 0);
      step();
      step();
      rst = 1'b1;

      repeat (300) step();
      check("frz_start_h", 32'(d_hcount), 300);
      en = 1'b0;
      s_lt_n = 0;
      s_tt_n = 0;
      d_lt_n = 0;
      for (int n = 0; n < 50; n++) begin
         step();
         count_ticks();
      end
      check("frz_h", 32'(d_hcount), 300);
      check("frz_v", 32'(d_vcount), 0);
      check("frz_s_frame", 32'(s_frame), 2);
      check("frz_s_lt", 32'(s_lt_n), 0);
      check("frz_d_lt", 32'(d_lt_n), 0);

      en = 1'b1;
      step();
      check("resume_h", 32'(d_hcount), 301);
      k = 1;
      while (!s_tt && k < 200) begin
         step();
         k++;
      end
      check("resume_tt_delay", 32'(k), 90);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: the next-generation replacement for the fixed 800x600 timing source at the head of the draw pipeline. It produces the horizontal and vertical counters, sync and blanking signals, a data-enable, a per-line pulse, a frame counter, and a game-logic tick on a configurable line. Resolution, porches, sync polarity and pixel-clock division are parameters, and a run-time enable freezes the raster. Its outputs feed the background/score/ball drawing stages and the ball controller tick.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- H_POL, 1, hsync active level (1 = active-high)
- V_POL, 1, vsync active level
- PIX_DIV, 1, clk cycles per pixel (≥1)
- TICK_LINE, V_ACTIVE, vcount at which timing_tick fires (< V_TOTAL)
- CNT_W, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_W, 16, frame counter width
- Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- en  in  1  run enable; 0 freezes all counters
- hcount  out  CNT_W  pixel index in line, 0..H_TOTAL-1
- vcount  out  CNT_W  line index in frame, 0..V_TOTAL-1
- hsync, vsync  out  1  sync at configured polarity
- hblnk, vblnk  out  1  blanking, active-high
- de  out  1  active video (!hblnk && !vblnk)
- line_tick  out  1  one-clk pulse when hcount enters 0
- timing_tick  out  1  one-clk pulse when (hcount,vcount) enters (0,TICK_LINE)
- frame_cnt  out  FRAME_W  completed frames, wraps

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056); V_TOTAL likewise (default 628). Elaboration error if any parameter is 0, PIX_DIV<1, TICK_LINE≥V_TOTAL, or totals overflow CNT_W.
- Divider div (0..PIX_DIV-1) counts when en=1; advance = en && div==PIX_DIV-1. PIX_DIV=1: advance every en cycle.
- On advance: hcount increments; at H_TOTAL-1 wraps to 0 and vcount increments; vcount at V_TOTAL-1 wraps to 0 and frame_cnt increments (modulo 2^FRAME_W).
- hblnk = hcount≥H_ACTIVE; vblnk = vcount≥V_ACTIVE.
- hsync active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (default 840..967); inactive level = !H_POL. vsync likewise on vcount (default 601..604).
- All outputs registered and mutually aligned: hsync/hblnk/de/ticks in a cycle describe the hcount/vcount presented in that same cycle (decode from next-state count, not from registered count).
- line_tick / timing_tick: high exactly one clk, in the cycle after the advance edge into hcount=0 (resp. (0,TICK_LINE)), regardless of PIX_DIV; never high while en=0.
- en=0: div, counters, sync, blank, frame_cnt hold; ticks 0. en returning to 1 resumes from held div value.

## Timing
- Reset (rst=0, async): hcount=0, vcount=0, div=0, frame_cnt=0, hblnk=0, vblnk=0, de=1, hsync=!H_POL, vsync=!V_POL, line_tick=0, timing_tick=0.
- Reset position (0,0) does not generate line_tick; timing_tick at reset only if its condition is re-entered.
- After release with en=1: first advance on the PIX_DIV-th rising edge; hcount=1 visible after it.
- Steady state: line_tick period H_TOTAL·PIX_DIV clk; timing_tick and frame_cnt increment period H_TOTAL·V_TOTAL·PIX_DIV clk.
- Reset mid-frame: outputs return to reset values asynchronously; no partial tick pulse emitted.
- Simultaneous h and v wrap at (H_TOTAL-1,V_TOTAL-1): single edge yields (0,0), frame_cnt+1, line_tick=1; timing_tick=1 only if TICK_LINE=0.

## Test plan
- Reset: hold rst=0, toggle clk -> all outputs at reset values listed; release, en=1 -> hcount=1 after first edge (PIX_DIV=1).
- Default horizontal: hsync rises entering hcount=840, falls entering 968; hblnk rises entering 800; line_tick every 1056 clk.
- Default frame: timing_tick (TICK_LINE=600) pulses once per 663168 clk, one clk wide, coincident with vcount=600, hcount=0; vsync active vcount 601..604; frame_cnt increments at (0,0).
- PIX_DIV=2, H_POL=0, V_POL=0 -> line_tick period 2112 clk, ticks still one clk wide; hsync low 840..967, high otherwise.
- en dropped for 50 clk mid-line at hcount=300 -> counters frozen at 300, ticks suppressed, resumes at 301; next timing_tick delayed by exactly 50 clk.
- Reset asserted at vcount=400 -> immediate return to (0,0), frame_cnt=0; after release next timing_tick after 600·1056 pixels.
